// File: rtl/krnl_rtl_axi_read_issuer.sv
// AXI read-address issuer: splits a byte-sized transfer into bursts and caps the bursts in flight.
// Optional stall counter output is enabled by defining KRNL_RTL_AXI_READ_ISSUER_STALL_CNT_EN.
module krnl_rtl_axi_read_issuer #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_BURST_LEN       = 16,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    output logic                         ctrl_done,
    output logic                         busy,
    output logic                         arvalid,
    input  logic                         arready,
    output logic [C_ADDR_WIDTH-1:0]      araddr,
    output logic [7:0]                   arlen,
    input  logic                         rvalid,
    input  logic                         rready,
    input  logic                         rlast
`ifdef KRNL_RTL_AXI_READ_ISSUER_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cycles
`endif
);

    localparam int BPB         = C_DATA_WIDTH / 8;
    localparam int BPB_LG      = $clog2(BPB);
    localparam int BL_LG       = $clog2(C_BURST_LEN);
    localparam int XW          = C_XFER_SIZE_WIDTH;
    localparam int OW          = $clog2(C_MAX_OUTSTANDING + 1);
    localparam int BURST_BYTES = C_BURST_LEN * BPB;

    localparam logic [OW-1:0] MAX_OUT  = OW'(C_MAX_OUTSTANDING);
    localparam logic [7:0]    FULL_LEN = 8'(C_BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    arvalid_q;
    logic                    ctrl_done_q;
    logic                    busy_q;
    logic [C_ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]              arlen_q;
    logic [7:0]              last_len_q;
    logic [XW-1:0]           bursts_left_q;
    logic [OW-1:0]           out_q;
    logic [OW-1:0]           out_d;

    logic                    ar_hs_s;
    logic                    r_last_s;
    logic [XW:0]             size_ext_s;
    logic [XW-1:0]           beats_s;
    logic [XW-1:0]           bursts_s;
    logic [7:0]              last_len_s;

    // Handshake decode, outstanding next-state and start-time burst arithmetic
    always_comb begin
        ar_hs_s    = arvalid_q & arready;
        r_last_s   = rvalid & rready & rlast;
        size_ext_s = {1'b0, ctrl_xfer_size_in_bytes};
        beats_s    = XW'((size_ext_s + (XW+1)'(BPB - 1)) >> BPB_LG);
        bursts_s   = XW'(({1'b0, beats_s} + (XW+1)'(C_BURST_LEN - 1)) >> BL_LG);
        last_len_s = 8'(beats_s - XW'(1)) & FULL_LEN;
        // A stray rlast with nothing in flight must not wrap the counter
        if (ar_hs_s && !r_last_s) begin
            out_d = out_q + OW'(1);
        end else if (!ar_hs_s && r_last_s && (out_q != OW'(0))) begin
            out_d = out_q - OW'(1);
        end else begin
            out_d = out_q;
        end
    end

    // Control FSM with registered AR channel and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            arvalid_q     <= 1'b0;
            ctrl_done_q   <= 1'b0;
            busy_q        <= 1'b0;
            araddr_q      <= {C_ADDR_WIDTH{1'b0}};
            arlen_q       <= 8'd0;
            last_len_q    <= 8'd0;
            bursts_left_q <= {XW{1'b0}};
            out_q         <= {OW{1'b0}};
        end else begin
            out_q       <= out_d;
            ctrl_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        araddr_q      <= ctrl_addr_offset;
                        bursts_left_q <= bursts_s;
                        last_len_q    <= last_len_s;
                        arlen_q       <= (bursts_s == XW'(1)) ? last_len_s : FULL_LEN;
                        busy_q        <= 1'b1;
                        if (ctrl_xfer_size_in_bytes == XW'(0)) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q   <= ST_ISSUE;
                            arvalid_q <= (out_d < MAX_OUT);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (ar_hs_s) begin
                        araddr_q      <= araddr_q + C_ADDR_WIDTH'(BURST_BYTES);
                        bursts_left_q <= bursts_left_q - XW'(1);
                        arlen_q       <= (bursts_left_q == XW'(2)) ? last_len_q : FULL_LEN;
                        if (bursts_left_q == XW'(1)) begin
                            arvalid_q <= 1'b0;
                            state_q   <= ST_DRAIN;
                        end else begin
                            arvalid_q <= (out_d < MAX_OUT);
                        end
                    end else if (!arvalid_q) begin
                        // Throttled by the in-flight limit; re-raise once a burst retires
                        arvalid_q <= (out_d < MAX_OUT);
                    end
                end
                ST_DRAIN: begin
                    if (out_q == OW'(0)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ctrl_done_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    arvalid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ctrl_done = ctrl_done_q;
    assign busy      = busy_q;
    assign arvalid   = arvalid_q;
    assign araddr    = araddr_q;
    assign arlen     = arlen_q;

`ifdef KRNL_RTL_AXI_READ_ISSUER_STALL_CNT_EN
    logic [31:0] stall_q;
    logic        stall_s;

    // A cycle stalls when the slave back-pressures or the in-flight limit holds AR off
    always_comb begin
        if (arvalid_q && !arready) begin
            stall_s = 1'b1;
        end else if ((state_q == ST_ISSUE) && !arvalid_q && (out_q == MAX_OUT)) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Saturating stall counter, restarted with each accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else if ((state_q == ST_IDLE) && ctrl_start) begin
            stall_q <= 32'd0;
        end else if (stall_s && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_krnl_rtl_axi_read_issuer.sv
// Self-checking bench: table-driven and randomized transfers against a transaction-level model.
module tb_krnl_rtl_axi_read_issuer;

    localparam int MAX_OUT = 4;
    localparam int BPB     = 64;
    localparam int BL      = 16;
    localparam int BUDGET  = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_start;
    logic [63:0] ctrl_addr_offset;
    logic [31:0] ctrl_xfer_size_in_bytes;
    logic        ctrl_done;
    logic        busy;
    logic        arvalid;
    logic        arready;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid;
    logic        rready;
    logic        rlast;
`ifdef KRNL_RTL_AXI_READ_ISSUER_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    krnl_rtl_axi_read_issuer #(
        .C_MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .ctrl_start              (ctrl_start),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ctrl_done               (ctrl_done),
        .busy                    (busy),
        .arvalid                 (arvalid),
        .arready                 (arready),
        .araddr                  (araddr),
        .arlen                   (arlen),
        .rvalid                  (rvalid),
        .rready                  (rready),
        .rlast                   (rlast)
`ifdef KRNL_RTL_AXI_READ_ISSUER_STALL_CNT_EN
        ,
        .stall_cycles            (stall_cycles)
`endif
    );

    typedef struct {
        logic [63:0] off;
        logic [31:0] size;
        int          exp_n;
        logic [7:0]  exp_last;
        int          rdy;
        int          rl;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one transfer acting as AXI slave; checks every AR, the in-flight gate and done timing.
    task automatic run_xfer(input logic [63:0] off, input logic [31:0] size, input int rdy_pct,
                            input int rl_pct, input int exp_n, input logic [7:0] exp_last,
                            input int rdy_delay, input int rl_hold, output int n_at_hold);
        int n_ar = 0;
        int pend = 0;
        int dones = 0;
        int done_cyc = -1;
        int exp_done = -1;
        int st = 0;
        bit pv = 1'b0;
        bit phs = 1'b0;
        bit rd;
        bit pulse;
        logic [63:0] pa = 64'd0;
        logic [7:0]  pl = 8'd0;
        n_at_hold = -1;
        @(negedge clk);
        ctrl_addr_offset = off;
        ctrl_xfer_size_in_bytes = size;
        ctrl_start = 1'b1;
        arready = 1'b0;
        rvalid = 1'b0;
        rready = 1'b0;
        rlast = 1'b0;
        @(negedge clk);
        ctrl_start = 1'b0;
        if (exp_n == 0) exp_done = 2;
        for (int c = 1; c <= BUDGET; c++) begin
            // Drain finishes: DONE the cycle after nothing is in flight, pulse the cycle after that
            if (exp_n > 0 && exp_done < 0 && n_ar == exp_n && pend == 0) exp_done = c + 2;
            if (ctrl_done) begin
                dones++;
                done_cyc = c;
            end
            chk("busy", busy, dones == 0);
            chk("arvalid_gate", arvalid, (n_ar < exp_n) && (pend < MAX_OUT));
            if (pv && !phs) begin
                chk("araddr_hold", araddr, pa);
                chk("arlen_hold", arlen, pl);
            end
            if (c == rl_hold) n_at_hold = n_ar;
            if (done_cyc > 0 && c >= done_cyc + 2) break;
            rd = (c > rdy_delay) && ($urandom_range(99, 0) < rdy_pct);
            pulse = (pend > 0) && (c > rl_hold) && ($urandom_range(99, 0) < rl_pct);
            arready = rd;
            if (pulse) begin
                rvalid = 1'b1;
                rready = 1'b1;
                rlast = 1'b1;
            end else begin
                rvalid = 1'($urandom_range(1, 0));
                rready = 1'($urandom_range(1, 0));
                rlast = (rvalid && rready) ? 1'b0 : 1'($urandom_range(1, 0));
            end
            if (arvalid && !rd) st++;
            else if (!arvalid && n_ar < exp_n && pend == MAX_OUT) st++;
            if (arvalid && rd) begin
                chk("araddr", araddr, off + 64'(n_ar) * 64'(BL * BPB));
                chk("arlen", arlen, (n_ar == exp_n - 1) ? exp_last : 8'(BL - 1));
                n_ar++;
                pend++;
            end
            if (pulse) pend--;
            pv = arvalid;
            phs = arvalid && rd;
            pa = araddr;
            pl = arlen;
            @(negedge clk);
        end
        arready = 1'b0;
        rvalid = 1'b0;
        rready = 1'b0;
        rlast = 1'b0;
        chk("ar_count", n_ar, exp_n);
        chk("done_count", dones, 1);
        chk("done_cycle", done_cyc, exp_done);
`ifdef KRNL_RTL_AXI_READ_ISSUER_STALL_CNT_EN
        chk("stall_model", stall_cycles, st);
`endif
    endtask

    initial begin
        int nh;
        int hs;
        tbl[0] = '{64'h1000, 32'd4096, 4, 8'd15, 100, 60};
        tbl[1] = '{64'h0, 32'd1100, 2, 8'd1, 100, 50};
        tbl[2] = '{64'h40, 32'd64, 1, 8'd0, 100, 100};
        tbl[3] = '{64'h0, 32'd1, 1, 8'd0, 70, 50};
        tbl[4] = '{64'h8000, 32'd1024, 1, 8'd15, 50, 50};
        tbl[5] = '{64'h0, 32'd1025, 2, 8'd0, 100, 100};
        tbl[6] = '{64'h2000, 32'd2112, 3, 8'd0, 80, 40};
        tbl[7] = '{64'h100, 32'd960, 1, 8'd14, 100, 30};
        tbl[8] = '{64'hFFFF_FFFF_FFFF_FC00, 32'd2048, 2, 8'd15, 100, 50};
        tbl[9] = '{64'h0, 32'd0, 0, 8'd0, 100, 50};

        rst = 1'b1;
        ctrl_start = 1'b0;
        ctrl_addr_offset = 64'd0;
        ctrl_xfer_size_in_bytes = 32'd0;
        arready = 1'b0;
        rvalid = 1'b0;
        rready = 1'b0;
        rlast = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", ctrl_done, 1'b0);
        chk("rst_araddr", araddr, 64'd0);
        chk("rst_arlen", arlen, 8'd0);
`ifdef KRNL_RTL_AXI_READ_ISSUER_STALL_CNT_EN
        chk("rst_stall", stall_cycles, 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_xfer(tbl[i].off, tbl[i].size, tbl[i].rdy, tbl[i].rl, tbl[i].exp_n,
                     tbl[i].exp_last, 0, 0, nh);
        end

        // Full back-pressure for five cycles on a single burst
        run_xfer(64'h4000, 32'd1024, 100, 100, 1, 8'd15, 5, 0, nh);
`ifdef KRNL_RTL_AXI_READ_ISSUER_STALL_CNT_EN
        chk("stall_five", stall_cycles, 32'd5);
`endif

        // In-flight limit: no rlast for 20 cycles leaves exactly MAX_OUT bursts issued
        run_xfer(64'h0, 32'd8192, 100, 100, 8, 8'd15, 0, 20, nh);
        chk("limit_ars", nh, MAX_OUT);

        // Stray rlasts while idle must leave the counter at zero
        @(negedge clk);
        rvalid = 1'b1;
        rready = 1'b1;
        rlast = 1'b1;
        repeat (2) @(negedge clk);
        rvalid = 1'b0;
        rready = 1'b0;
        rlast = 1'b0;
        run_xfer(64'h0, 32'd4096, 100, 100, 4, 8'd15, 0, 8, nh);
        chk("underflow_ars", nh, MAX_OUT);

        // Reset after two of four bursts, then a fresh transfer
        @(negedge clk);
        ctrl_addr_offset = 64'h1000;
        ctrl_xfer_size_in_bytes = 32'd4096;
        ctrl_start = 1'b1;
        arready = 1'b1;
        @(negedge clk);
        ctrl_start = 1'b0;
        hs = 0;
        for (int c = 0; c < 20 && hs < 2; c++) begin
            if (arvalid) hs++;
            @(negedge clk);
        end
        chk("mid_rst_hs", hs, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_arvalid", arvalid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", ctrl_done, 1'b0);
        chk("mid_rst_araddr", araddr, 64'd0);
        chk("mid_rst_arlen", arlen, 8'd0);
        rst = 1'b0;
        arready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_done", ctrl_done, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
        end
        run_xfer(64'h0, 32'd1024, 100, 100, 1, 8'd15, 0, 0, nh);

        // Randomized transfers checked against ceil arithmetic
        for (int k = 0; k < 16; k++) begin
            logic [63:0] o;
            logic [31:0] s;
            longint beats;
            longint bursts;
            s = 32'($urandom_range(6000, 0));
            o = {$urandom, $urandom} & ~64'h3F;
            beats = (longint'(s) + BPB - 1) / BPB;
            bursts = (beats + BL - 1) / BL;
            run_xfer(o, s, $urandom_range(100, 30), $urandom_range(90, 20), int'(bursts),
                     (beats > 0) ? 8'((beats - 1) % BL) : 8'd0, 0, 0, nh);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
